// File: rtl/rx_block_lock.sv
// rx_block_lock
//   64b/66b block-lock state machine for one GT receive lane. Hunts for the
//   sync-header boundary by requesting gearbox slips, declares lock after
//   LOCK_COUNT consecutive valid headers, and drops lock when BAD_LIMIT
//   invalid headers land inside one WINDOW-header monitoring window.
//
// Ports
//   clk             lane receive user clock
//   rst             synchronous active-high reset
//   rx_header       2-bit sync header of the current block
//   rx_header_valid rx_header is meaningful this cycle
//   rx_slip         one-cycle gearbox slip request
//   channel_good    block lock held (feeds the datapath reset watchdog)
//   lock_lost       one-cycle pulse when lock is dropped
//   slip_count      saturating count of slips since rst
module rx_block_lock #(
    parameter int LOCK_COUNT = 64,
    parameter int WINDOW     = 1024,
    parameter int BAD_LIMIT  = 16,
    parameter int SLIP_WAIT  = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] rx_header,
    input  logic       rx_header_valid,
    output logic       rx_slip,
    output logic       channel_good,
    output logic       lock_lost,
    output logic [7:0] slip_count
);

    localparam int GW = $clog2(LOCK_COUNT) + 1;
    localparam int WW = $clog2(WINDOW) + 1;
    localparam int BW = $clog2(BAD_LIMIT) + 1;
    localparam int TW = $clog2(SLIP_WAIT) + 1;

    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_COUNT - 1);
    localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW - 1);
    localparam logic [BW-1:0] BAD_LAST  = BW'(BAD_LIMIT - 1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(SLIP_WAIT - 1);

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_SLIP,
        ST_SLIP_WAIT,
        ST_LOCKED
    } state_t;

    state_t          r_state;
    logic [GW-1:0]   r_good_cnt;
    logic [WW-1:0]   r_win_cnt;
    logic [BW-1:0]   r_bad_cnt;
    logic [TW-1:0]   r_wait_cnt;
    logic            r_rx_slip;
    logic            r_channel_good;
    logic            r_lock_lost;
    logic [7:0]      r_slip_count;

    state_t          w_state_nxt;
    logic [GW-1:0]   w_good_nxt;
    logic [WW-1:0]   w_win_nxt;
    logic [BW-1:0]   w_bad_nxt;
    logic [TW-1:0]   w_wait_nxt;
    logic            w_slip_nxt;
    logic            w_lost_nxt;
    logic [7:0]      w_slip_count_nxt;
    logic            w_hdr_sync;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // 01 and 10 are the only legal sync headers.
    assign w_hdr_sync = rx_header[1] ^ rx_header[0];

    always_comb begin
        w_state_nxt      = r_state;
        w_good_nxt       = r_good_cnt;
        w_win_nxt        = r_win_cnt;
        w_bad_nxt        = r_bad_cnt;
        w_wait_nxt       = r_wait_cnt;
        w_slip_nxt       = 1'b0;
        w_lost_nxt       = 1'b0;
        w_slip_count_nxt = r_slip_count;

        case (r_state)
            ST_HUNT: begin
                if (rx_header_valid) begin
                    if (!w_hdr_sync) begin
                        w_good_nxt  = '0;
                        w_state_nxt = ST_SLIP;
                    end else if (r_good_cnt == GOOD_LAST) begin
                        w_good_nxt  = '0;
                        w_state_nxt = ST_LOCKED;
                    end else begin
                        w_good_nxt = r_good_cnt + GW'(1);
                    end
                end
            end
            ST_SLIP: begin
                // The registered slip pulse is launched from this state, so it
                // appears during the first SLIP_WAIT cycle.
                w_slip_nxt       = 1'b1;
                w_slip_count_nxt = sat_inc8(r_slip_count);
                w_wait_nxt       = '0;
                w_state_nxt      = ST_SLIP_WAIT;
            end
            ST_SLIP_WAIT: begin
                if (r_wait_cnt == WAIT_LAST) begin
                    w_wait_nxt  = '0;
                    w_good_nxt  = '0;
                    w_state_nxt = ST_HUNT;
                end else begin
                    w_wait_nxt = r_wait_cnt + TW'(1);
                end
            end
            ST_LOCKED: begin
                if (rx_header_valid) begin
                    // Loss of lock is tested first so it wins over a window
                    // boundary on the same header.
                    if (!w_hdr_sync && (r_bad_cnt == BAD_LAST)) begin
                        w_win_nxt   = '0;
                        w_bad_nxt   = '0;
                        w_lost_nxt  = 1'b1;
                        w_state_nxt = ST_SLIP;
                    end else if (r_win_cnt == WIN_LAST) begin
                        w_win_nxt = '0;
                        w_bad_nxt = '0;
                    end else begin
                        w_win_nxt = r_win_cnt + WW'(1);
                        w_bad_nxt = r_bad_cnt + {{(BW-1){1'b0}}, ~w_hdr_sync};
                    end
                end
            end
            default: begin
                w_state_nxt = ST_HUNT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_HUNT;
            r_good_cnt     <= '0;
            r_win_cnt      <= '0;
            r_bad_cnt      <= '0;
            r_wait_cnt     <= '0;
            r_rx_slip      <= 1'b0;
            r_channel_good <= 1'b0;
            r_lock_lost    <= 1'b0;
            r_slip_count   <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_good_cnt     <= w_good_nxt;
            r_win_cnt      <= w_win_nxt;
            r_bad_cnt      <= w_bad_nxt;
            r_wait_cnt     <= w_wait_nxt;
            r_rx_slip      <= w_slip_nxt;
            r_channel_good <= (w_state_nxt == ST_LOCKED);
            r_lock_lost    <= w_lost_nxt;
            r_slip_count   <= w_slip_count_nxt;
        end
    end

    assign rx_slip      = r_rx_slip;
    assign channel_good = r_channel_good;
    assign lock_lost    = r_lock_lost;
    assign slip_count   = r_slip_count;

endmodule

// File: tb/tb_rx_block_lock.sv
// Testbench for rx_block_lock: reset/slip vector table, directed multi-cycle
// sequences, and randomized traffic compared against a behavioural model.
module tb_rx_block_lock;

    localparam int LOCK_COUNT = 64;
    localparam int WINDOW     = 1024;
    localparam int BAD_LIMIT  = 16;
    localparam int SLIP_WAIT  = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] rx_header = 2'b00;
    logic       rx_header_valid = 1'b0;
    logic       rx_slip;
    logic       channel_good;
    logic       lock_lost;
    logic [7:0] slip_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    rx_block_lock #(
        .LOCK_COUNT(LOCK_COUNT),
        .WINDOW    (WINDOW),
        .BAD_LIMIT (BAD_LIMIT),
        .SLIP_WAIT (SLIP_WAIT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_header      (rx_header),
        .rx_header_valid(rx_header_valid),
        .rx_slip        (rx_slip),
        .channel_good   (channel_good),
        .lock_lost      (lock_lost),
        .slip_count     (slip_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: lock flag, run of good headers, pending slip,
    // remaining wait cycles, and header/bad tallies of the current window.
    bit m_locked, m_slip_req, e_slip, e_lost;
    int m_run, m_wait, m_win, m_bad, m_slips;

    function automatic void model_step(input bit r, input bit v, input logic [1:0] h);
        bit ok;
        ok = (h == 2'b01) || (h == 2'b10);
        e_slip = 1'b0;
        e_lost = 1'b0;
        if (r) begin
            m_locked = 0; m_slip_req = 0; m_run = 0; m_wait = 0;
            m_win = 0; m_bad = 0; m_slips = 0;
        end else if (m_slip_req) begin
            m_slip_req = 0;
            e_slip = 1'b1;
            if (m_slips < 255) m_slips++;
            m_wait = SLIP_WAIT;
        end else if (m_wait > 0) begin
            m_wait--;
        end else if (m_locked) begin
            if (v) begin
                m_win++;
                if (!ok) m_bad++;
                if (!ok && m_bad == BAD_LIMIT) begin
                    m_locked = 0; e_lost = 1'b1; m_slip_req = 1; m_win = 0; m_bad = 0;
                end else if (m_win == WINDOW) begin
                    m_win = 0; m_bad = 0;
                end
            end
        end else if (v) begin
            if (ok) begin
                m_run++;
                if (m_run == LOCK_COUNT) begin
                    m_locked = 1; m_run = 0;
                end
            end else begin
                m_run = 0; m_slip_req = 1;
            end
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model with the same edge, and
    // compare all outputs against it just after the edge.
    task automatic step(input logic r, input logic v, input logic [1:0] h);
        rst = r;
        rx_header_valid = v;
        rx_header = h;
        @(posedge clk);
        cyc++;
        model_step(r, v, h);
        #1;
        checks++;
        if ({rx_slip, channel_good, lock_lost, slip_count} !==
            {e_slip, m_locked, e_lost, 8'(m_slips)}) begin
            failures++;
            $display("FAIL model at cycle %0d: got slip=%b good=%b lost=%b cnt=%0d expected slip=%b good=%b lost=%b cnt=%0d",
                     cyc, rx_slip, channel_good, lock_lost, slip_count,
                     e_slip, m_locked, e_lost, m_slips);
        end
    endtask

    task automatic good_hdrs(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, (i % 2 == 0) ? 2'b01 : 2'b10);
    endtask

    typedef struct {
        logic       r;
        logic       v;
        logic [1:0] h;
        logic       slip;
        logic       good;
        logic       lost;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[13];
    bit   saw_lost;
    logic [1:0] hh;
    int   bad_rate;

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[1]  = '{1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[2]  = '{1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[3]  = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[4]  = '{1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[5]  = '{1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[6]  = '{1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 8'd1};
        tbl[7]  = '{1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'd1};
        tbl[8]  = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'd1};
        tbl[9]  = '{1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[10] = '{1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[11] = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[12] = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0};

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].r, tbl[i].v, tbl[i].h);
            check($sformatf("vec%0d", i),
                  {21'd0, rx_slip, channel_good, lock_lost, slip_count},
                  {21'd0, tbl[i].slip, tbl[i].good, tbl[i].lost, tbl[i].cnt});
        end

        // Lock acquisition: channel_good rises right after the 64th header.
        step(1'b1, 1'b0, 2'b00);
        good_hdrs(LOCK_COUNT - 1);
        check("acq_before", channel_good, 0);
        good_hdrs(1);
        check("acq_good", channel_good, 1);
        check("acq_slipcnt", slip_count, 0);

        // Hunt slip on the 10th header, discarded headers while waiting, relock.
        step(1'b1, 1'b0, 2'b00);
        good_hdrs(9);
        step(1'b0, 1'b1, 2'b11);
        check("hunt_noslip_yet", rx_slip, 0);
        step(1'b0, 1'b1, 2'b11);
        check("hunt_slip", rx_slip, 1);
        check("hunt_slipcnt", slip_count, 1);
        for (int i = 0; i < SLIP_WAIT; i++) step(1'b0, 1'b1, 2'b11);
        check("hunt_wait_noslip", rx_slip, 0);
        good_hdrs(LOCK_COUNT);
        check("hunt_relock", channel_good, 1);
        check("hunt_slipcnt2", slip_count, 1);

        // Valid on alternate cycles only; unqualified 2'b00 must be ignored.
        step(1'b1, 1'b0, 2'b00);
        for (int i = 0; i < 2 * LOCK_COUNT; i++) begin
            if (i % 2 == 0) step(1'b0, 1'b0, 2'b00);
            else            step(1'b0, 1'b1, 2'b01);
            if (i == 2 * LOCK_COUNT - 2) check("gap_before", channel_good, 0);
        end
        check("gap_good", channel_good, 1);
        check("gap_slipcnt", slip_count, 0);

        // Loss of lock: 16 invalid headers well inside one window.
        step(1'b1, 1'b0, 2'b00);
        good_hdrs(LOCK_COUNT);
        for (int j = 0; j < 160; j++) begin
            step(1'b0, 1'b1, (j % 10 == 9) ? 2'b00 : 2'b10);
            if (j == 148) check("loss_still_locked", channel_good, 1);
        end
        check("loss_good", channel_good, 0);
        check("loss_pulse", lock_lost, 1);
        check("loss_slip_not_yet", rx_slip, 0);
        step(1'b0, 1'b0, 2'b00);
        check("loss_slip", rx_slip, 1);
        check("loss_pulse_end", lock_lost, 0);

        // 15 invalid headers per window for 3 windows keeps lock.
        step(1'b1, 1'b0, 2'b00);
        good_hdrs(LOCK_COUNT);
        saw_lost = 0;
        for (int p = 0; p < 3 * WINDOW; p++) begin
            if ((p % WINDOW) < 15 * 64 && (p % 64) == 5) step(1'b0, 1'b1, 2'b11);
            else                                         step(1'b0, 1'b1, 2'b01);
            if (lock_lost || !channel_good) saw_lost = 1;
        end
        check("retain_flag", saw_lost, 0);
        check("retain_good", channel_good, 1);

        // 16th invalid header is the last header of the window: loss wins.
        step(1'b1, 1'b0, 2'b00);
        good_hdrs(LOCK_COUNT);
        for (int p = 0; p < WINDOW; p++) begin
            step(1'b0, 1'b1, (p < 15 || p == WINDOW - 1) ? 2'b00 : 2'b10);
            if (p == WINDOW - 2) check("edge_before", channel_good, 1);
        end
        check("edge_good", channel_good, 0);
        check("edge_lost", lock_lost, 1);

        // 300 slips saturate the counter.
        step(1'b1, 1'b0, 2'b00);
        for (int s = 0; s < 300; s++) begin
            step(1'b0, 1'b1, 2'b11);
            for (int i = 0; i < SLIP_WAIT + 1; i++) step(1'b0, 1'b0, 2'b00);
            if (s == 253) check("sat_254", slip_count, 254);
        end
        check("sat_255", slip_count, 255);

        // Reset during SLIP_WAIT clears everything on the next edge.
        step(1'b0, 1'b1, 2'b11);
        step(1'b0, 1'b0, 2'b00);
        step(1'b0, 1'b0, 2'b00);
        step(1'b1, 1'b0, 2'b00);
        check("rstwait_all",
              {21'd0, rx_slip, channel_good, lock_lost, slip_count}, 32'd0);

        // Randomized traffic with varying bad-header density.
        for (int blk = 0; blk < 12; blk++) begin
            case ($urandom_range(0, 3))
                0:       bad_rate = 0;
                1:       bad_rate = 5;
                2:       bad_rate = 25;
                default: bad_rate = 120;
            endcase
            for (int i = 0; i < 500; i++) begin
                if ($urandom_range(0, 999) < bad_rate) hh = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
                else                                   hh = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
                step(($urandom_range(0, 1999) == 0), ($urandom_range(0, 3) != 0), hh);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
